// File: rtl/mux8_rr_arbiter_if.sv
// Handshake/data bundle between 8 requesters and the round-robin mux arbiter.
// MUX_ARB_LOCK_EN adds the lock input that lets the holder keep the channel past HOLD_MAX.
interface mux8_rr_arbiter_if #(
  parameter int DW = 1
) ();
  logic [7:0]      req;
  logic [8*DW-1:0] din;
`ifdef MUX_ARB_LOCK_EN
  logic            lock;
`endif
  logic [7:0]      gnt;
  logic [2:0]      sel;
  logic [DW-1:0]   dout;
  logic            dout_vld;
  logic            busy;

`ifdef MUX_ARB_LOCK_EN
  modport master (output req, din, lock, input gnt, sel, dout, dout_vld, busy);
  modport slave  (input req, din, lock, output gnt, sel, dout, dout_vld, busy);
`else
  modport master (output req, din, input gnt, sel, dout, dout_vld, busy);
  modport slave  (input req, din, output gnt, sel, dout, dout_vld, busy);
`endif
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving an 8:1 mux select; req-to-gnt 1 cycle, dout lags sel by 1 cycle.
// Grants bounded to HOLD_MAX cycles; MUX_ARB_LOCK_EN adds a lock input that suppresses the timeout.
module mux8_rr_arbiter #(
  parameter int DW       = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux8_rr_arbiter_if.slave bus
);
  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          r_state;
  logic [2:0]      r_ptr;
  logic [2:0]      r_sel;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_gnt;
  logic [DW-1:0]   r_dout;
  logic            r_dout_vld;
  logic            r_busy;

  logic            w_hold_req;
  logic            w_tmo;
  logic            w_release;
  logic [2:0]      w_base;
  logic [7:0]      w_cand;
  logic [2:0]      w_idx;
  logic            w_found;
  logic [2:0]      w_win;

  always_comb begin
    w_hold_req = bus.req[r_sel];
`ifdef MUX_ARB_LOCK_EN
    w_tmo      = (r_cnt == CNT_LAST) && !(bus.lock && w_hold_req);
`else
    w_tmo      = (r_cnt == CNT_LAST);
`endif
    w_release  = !w_hold_req || w_tmo;
    w_base     = (r_state == GRANT) ? r_sel + 3'd1 : r_ptr;
    w_cand     = bus.req;
    // A holder that dropped its request must not win its own re-arbitration.
    if (r_state == GRANT && !w_hold_req) w_cand[r_sel] = 1'b0;
    w_idx   = '0;
    w_found = 1'b0;
    w_win   = '0;
    // Walk from farthest to nearest so the nearest set bit is assigned last.
    for (int k = 7; k >= 0; k--) begin
      w_idx = w_base + 3'(k);
      if (w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_dout_vld <= 1'b0;
          if (w_found) begin
            r_state <= GRANT;
            r_gnt   <= 8'b1 << w_win;
            r_sel   <= w_win;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        GRANT: begin
          r_dout     <= bus.din[r_sel*DW +: DW];
          r_dout_vld <= 1'b1;
          if (w_release) begin
            r_ptr <= r_sel + 3'd1;
            r_cnt <= '0;
            if (w_found) begin
              r_gnt <= 8'b1 << w_win;
              r_sel <= w_win;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
              r_sel   <= '0;
              r_busy  <= 1'b0;
            end
          end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.sel      = r_sel;
  assign bus.dout     = r_dout;
  assign bus.dout_vld = r_dout_vld;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized bench for mux8_rr_arbiter with a per-cycle reference model and directed literal checks.
module tb_mux8_rr_arbiter;
  localparam int DW       = 1;
  localparam int HOLD_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux8_rr_arbiter_if #(.DW(DW)) bus ();
  mux8_rr_arbiter #(.DW(DW), .HOLD_MAX(HOLD_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: holder index (-1 = idle), cycles shown so far, next search start.
  int            m_holder = -1;
  int            m_held   = 0;
  int            m_ptr    = 0;
  bit            m_ok     = 0;
  bit            m_lk;
  bit            m_drop;
  logic [7:0]    e_gnt    = '0;
  logic [2:0]    e_sel    = '0;
  logic [DW-1:0] e_dout   = '0;
  logic          e_vld    = 1'b0;
  logic          e_busy   = 1'b0;

  function automatic int find_winner(input logic [7:0] r, input int start, input int excl);
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (start + k) % 8;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_holder = -1;
      m_held   = 0;
      m_ptr    = 0;
      e_dout   = '0;
      e_vld    = 1'b0;
    end else if (m_holder < 0) begin
      e_vld    = 1'b0;
      m_holder = find_winner(bus.req, m_ptr, -1);
      m_held   = 1;
    end else begin
      e_dout = bus.din[m_holder*DW +: DW];
      e_vld  = 1'b1;
      m_lk   = 1'b0;
`ifdef MUX_ARB_LOCK_EN
      m_lk   = bus.lock;
`endif
      m_drop = !bus.req[m_holder];
      if (m_drop || (m_held >= HOLD_MAX && !(m_lk && bus.req[m_holder]))) begin
        m_ptr    = (m_holder + 1) % 8;
        m_holder = find_winner(bus.req, m_ptr, m_drop ? m_holder : -1);
        m_held   = 1;
      end else begin
        m_held++;
      end
    end
    e_gnt  = (m_holder < 0) ? 8'h00 : (8'b1 << m_holder);
    e_sel  = (m_holder < 0) ? 3'd0 : m_holder[2:0];
    e_busy = (m_holder >= 0);
    m_ok   = 1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("mdl_gnt", bus.gnt, e_gnt);
      chk("mdl_sel", bus.sel, e_sel);
      chk("mdl_dout", bus.dout, e_dout);
      chk("mdl_vld", bus.dout_vld, e_vld);
      chk("mdl_busy", bus.busy, e_busy);
    end
  end

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rand_req();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'b1 << $urandom_range(0, 7);
      2:       return 8'($urandom);
      default: return 8'hFF;
    endcase
  endfunction

  initial begin
    rst     = 1'b1;
    bus.req = '0;
    bus.din = '0;
`ifdef MUX_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    // Reset held with no requests.
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_sel", bus.sel, 0);
      chk("rst_dout", bus.dout, 0);
      chk("rst_vld", bus.dout_vld, 0);
      chk("rst_busy", bus.busy, 0);
    end

    // Single requester 2 for two cycles, then drop; next search starts at 3.
    rst     = 1'b0;
    bus.din = 8'h04;
    bus.req = 8'h04;
    @(negedge clk);
    chk("t2_gnt", bus.gnt, 8'h04);
    chk("t2_sel", bus.sel, 2);
    chk("t2_busy", bus.busy, 1);
    chk("t2_vld0", bus.dout_vld, 0);
    @(negedge clk);
    chk("t2_dout", bus.dout, 1);
    chk("t2_vld1", bus.dout_vld, 1);
    bus.req = 8'h00;
    @(negedge clk);
    chk("t2_gnt_off", bus.gnt, 0);
    chk("t2_busy_off", bus.busy, 0);
    chk("t2_vld_lag", bus.dout_vld, 1);
    @(negedge clk);
    chk("t2_vld_off", bus.dout_vld, 0);
    chk("t2_dout_keep", bus.dout, 1);
    bus.req = 8'h0C;
    @(negedge clk);
    chk("t2_ptr3", bus.gnt, 8'h08);

    // All requesting from reset: 0..7 then 0, four cycles each, no gap.
    do_reset();
    bus.req = 8'hFF;
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      chk("t3_order", bus.gnt, 32'(8'b1 << ((k / 4) % 8)));
      chk("t3_busy", bus.busy, 1);
    end

    // Pointer at 2 after grant to 1, then req=81: 7 first, then wrap to 0.
    do_reset();
    bus.req = 8'h02;
    @(negedge clk);
    chk("t4_g1", bus.gnt, 8'h02);
    bus.req = 8'h00;
    @(negedge clk);
    chk("t4_idle", bus.gnt, 0);
    bus.req = 8'h81;
    @(negedge clk);
    chk("t4_g7", bus.gnt, 8'h80);
    chk("t4_s7", bus.sel, 7);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("t4_g0", bus.gnt, 8'h01);

    // Lone holder times out and wraps back to itself.
    do_reset();
    bus.req = 8'h10;
    repeat (10) begin
      @(negedge clk);
      chk("t5_gnt", bus.gnt, 8'h10);
      chk("t5_busy", bus.busy, 1);
    end

    // Reset mid-grant, then first grant goes to 0.
    do_reset();
    bus.req = 8'hFF;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_gnt", bus.gnt, 0);
    chk("t6_sel", bus.sel, 0);
    chk("t6_dout", bus.dout, 0);
    chk("t6_vld", bus.dout_vld, 0);
    chk("t6_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_first", bus.gnt, 8'h01);

`ifdef MUX_ARB_LOCK_EN
    do_reset();
    bus.lock = 1'b1;
    bus.req  = 8'hFF;
    repeat (10) begin
      @(negedge clk);
      chk("lock_gnt", bus.gnt, 8'h01);
    end
    bus.lock = 1'b0;
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 99) == 0);
      bus.din = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus.req = rand_req();
`ifdef MUX_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) bus.lock = ~bus.lock;
`endif
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
